// File: rtl/lut_neuron_loader_pkg.sv
// Shared types and sizing helpers for the runtime-loadable LUT neuron.
package lut_neuron_loader_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    ACTIVE,
    ERR
  } state_t;

  localparam int unsigned IN_BITS_DEFAULT  = 8;
  localparam int unsigned OUT_BITS_DEFAULT = 2;
  localparam int unsigned DEPTH            = 2 ** IN_BITS_DEFAULT;

  // A zero-bit input word still needs a one-bit write index.
  function automatic int unsigned idx_width(input int unsigned in_bits);
    return (in_bits == 0) ? 1 : in_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// DEPTH x DATA_BITS distributed table: one write port, one registered read port.
module lut_neuron_ram #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; it holds its value between lookups.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lut_neuron_loader.sv
// Streams a neuron truth table into RAM, then serves latency-1 lookups like the ROM neuron.
module lut_neuron_loader
  import lut_neuron_loader_pkg::*;
#(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_last,
  input  logic                reload,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                loaded,
  output logic                err
);

  localparam int unsigned IW = idx_width(IN_BITS);
  localparam logic [IW-1:0] LASTIDX = '1;

  state_t        state;
  logic [IW-1:0] idx;
  logic          beat;
  logic          lookup;

  // A beat coinciding with reload is dropped rather than written.
  assign beat   = cfg_valid & cfg_ready & ~reload;
  assign lookup = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      idx       <= '0;
      cfg_ready <= 1'b1;
      in_ready  <= 1'b0;
      loaded    <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= lookup;
      if (reload) begin
        state     <= EMPTY;
        idx       <= '0;
        cfg_ready <= 1'b1;
        in_ready  <= 1'b0;
        loaded    <= 1'b0;
        err       <= 1'b0;
      end else begin
        case (state)
          EMPTY, LOAD: begin
            if (beat) begin
              if (cfg_last && idx == LASTIDX) begin
                state     <= ACTIVE;
                idx       <= '0;
                cfg_ready <= 1'b0;
                in_ready  <= 1'b1;
                loaded    <= 1'b1;
              end else if (cfg_last || idx == LASTIDX) begin
                state     <= ERR;
                idx       <= idx + 1'b1;
                cfg_ready <= 1'b0;
                err       <= 1'b1;
              end else begin
                state <= LOAD;
                idx   <= idx + 1'b1;
              end
            end
          end
          ACTIVE, ERR: ;
          default: state <= ERR;
        endcase
      end
    end
  end

  lut_neuron_ram #(
    .ADDR_BITS(IW),
    .DATA_BITS(OUT_BITS)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (beat & ~rst),
    .waddr(idx),
    .wdata(cfg_data),
    .re   (lookup),
    .raddr(in_data),
    .rdata(out_data)
  );

endmodule
